sysctrl_initiator: RTL and testbench



---
 rtl/sysctrl_pkg.sv | 23 ++
 rtl/sysctrl_initiator.sv | 151 +++++++++++++++
 tb/tb_sysctrl_initiator.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sysctrl_pkg.sv
// Shared definitions for the byte-strobe system-control link:
// command codes, status signature bytes and the initiator FSM states.
package sysctrl_pkg;

  localparam logic [7:0] CMD_STATUS  = 8'h00;
  localparam logic [7:0] CMD_LEDS    = 8'h01;
  localparam logic [7:0] CMD_COLOR   = 8'h02;
  localparam logic [7:0] CMD_BUTTONS = 8'h03;
  localparam logic [7:0] CMD_CONFIG  = 8'h04;
  localparam logic [7:0] CMD_IRQ     = 8'h05;

  localparam logic [7:0] STATUS_SIG0 = 8'h5C;
  localparam logic [7:0] STATUS_SIG1 = 8'h42;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_GAP,
    ST_DATA,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sysctrl_initiator.sv
// Initiator end of the byte-strobe system-control link: sends a start/command byte plus
// payload bytes and collects one reply byte per payload byte. Optional IRQ polling: SYSCTRL_INIT_IRQ_POLL_EN.
module sysctrl_initiator
  import sysctrl_pkg::*;
#(
  parameter  int MAX_LEN = 4,
  parameter  int GAP     = 2,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [7:0]           req_cmd,
  input  logic [LW-1:0]        req_len,
  input  logic [8*MAX_LEN-1:0] req_data,
  output logic                 rsp_valid,
  output logic [8*MAX_LEN-1:0] rsp_data,
  output logic                 busy,
  output logic                 data_out_strobe,
  output logic                 data_out_start,
  output logic [7:0]           data_out,
  input  logic [7:0]           data_in
`ifdef SYSCTRL_INIT_IRQ_POLL_EN
  ,
  input  logic                 int_n,
  output logic                 irq_valid,
  output logic [7:0]           irq_status
`endif
);

  localparam int GW = $clog2(GAP + 1);

  if (GAP < 1 || MAX_LEN < 1) begin : g_param_check
    $error("sysctrl_initiator: GAP and MAX_LEN must both be >= 1");
  end

  state_t               state, state_d;
  logic [7:0]           cmd_q;
  logic [LW-1:0]        len_q;
  logic [LW-1:0]        idx;
  logic [8*MAX_LEN-1:0] pay_q;
  logic [GW-1:0]        gap_cnt;
  logic                 accept, launch, gap_last, sample;
  logic [LW-1:0]        len_clamped;

  function automatic logic [7:0] byte_at(input logic [8*MAX_LEN-1:0] v, input logic [LW-1:0] i);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (i == LW'(k)) b = v[8*k +: 8];
    end
    return b;
  endfunction

  assign accept      = (state == ST_IDLE) && req_valid;
  assign len_clamped = (req_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : req_len;
  assign gap_last    = (gap_cnt == GW'(GAP - 1));
  // idx counts payload bytes already strobed, so idx==0 marks the gap after the command byte.
  assign sample      = (state == ST_GAP) && gap_last && (idx != '0);

`ifdef SYSCTRL_INIT_IRQ_POLL_EN
  logic poll_start, poll_q;
  assign poll_start = (state == ST_IDLE) && !req_valid && !int_n;
  assign launch     = accept || poll_start;
  assign rsp_valid  = (state == ST_DONE) && !poll_q;
  assign irq_valid  = (state == ST_DONE) && poll_q;
`else
  assign launch     = accept;
  assign rsp_valid  = (state == ST_DONE);
`endif

  assign req_ready       = (state == ST_IDLE);
  assign busy            = (state != ST_IDLE);
  assign data_out_strobe = (state == ST_CMD) || (state == ST_DATA);
  assign data_out_start  = (state == ST_CMD);

  always_comb begin
    data_out = 8'h00;
    if (state == ST_CMD)       data_out = cmd_q;
    else if (state == ST_DATA) data_out = byte_at(pay_q, idx);
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: if (launch) state_d = ST_CMD;
      ST_CMD:  state_d = ST_GAP;
      ST_DATA: state_d = ST_GAP;
      ST_GAP:  if (gap_last) state_d = (idx < len_q) ? ST_DATA : ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q    <= '0;
      len_q    <= '0;
      pay_q    <= '0;
      idx      <= '0;
      gap_cnt  <= '0;
      rsp_data <= '0;
`ifdef SYSCTRL_INIT_IRQ_POLL_EN
      poll_q     <= 1'b0;
      irq_status <= '0;
`endif
    end else begin
      if (accept) begin
        cmd_q    <= req_cmd;
        len_q    <= len_clamped;
        pay_q    <= req_data;
        idx      <= '0;
        rsp_data <= '0;
`ifdef SYSCTRL_INIT_IRQ_POLL_EN
        poll_q   <= 1'b0;
      end else if (poll_start) begin
        // Self-issued IRQ poll leaves the user response registers untouched.
        cmd_q    <= CMD_IRQ;
        len_q    <= LW'(1);
        pay_q    <= '0;
        idx      <= '0;
        poll_q   <= 1'b1;
`endif
      end

      if (state == ST_CMD || state == ST_DATA) gap_cnt <= '0;
      else if (state == ST_GAP)                gap_cnt <= gap_cnt + GW'(1);

      if (state == ST_DATA) idx <= idx + LW'(1);

`ifdef SYSCTRL_INIT_IRQ_POLL_EN
      if (sample && poll_q) begin
        irq_status <= data_in;
      end else if (sample) begin
`else
      if (sample) begin
`endif
        for (int k = 0; k < MAX_LEN; k++) begin
          if (idx == LW'(k + 1)) rsp_data[8*k +: 8] <= data_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_sysctrl_initiator.sv
// Scoreboard bench for sysctrl_initiator with an attached responder model;
// frame expectations are derived from request fields and the link timing rules.
module tb_sysctrl_initiator;

  localparam int MAX_LEN = 4;
  localparam int GAP     = 2;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [7:0]           req_cmd = '0;
  logic [LW-1:0]        req_len = '0;
  logic [8*MAX_LEN-1:0] req_data = '0;
  logic                 rsp_valid;
  logic [8*MAX_LEN-1:0] rsp_data;
  logic                 busy;
  logic                 data_out_strobe;
  logic                 data_out_start;
  logic [7:0]           data_out;
  logic [7:0]           data_in;

  sysctrl_initiator #(.MAX_LEN(MAX_LEN), .GAP(GAP)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_len(req_len), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .data_out_strobe(data_out_strobe), .data_out_start(data_out_start),
    .data_out(data_out), .data_in(data_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { int cyc; logic start; logic [7:0] b; } bus_t;
  typedef struct { int cyc; logic [8*MAX_LEN-1:0] d; } rsp_t;
  bus_t exp_bus[$];
  rsp_t exp_rsp[$];
  int   free_at = 0;
  logic [8*MAX_LEN-1:0] last_rsp = '0;

  // Responder behaviour: status returns its signature, other commands echo a scrambled payload.
  function automatic logic [7:0] reply(input logic [7:0] c, input int i, input logic [7:0] p);
    if (c == 8'h00) begin
      case (i)
        0: return 8'h5C;
        1: return 8'h42;
        2: return 8'h03;
        default: return 8'hA7;
      endcase
    end
    return p ^ c ^ 8'(8'h30 + i);
  endfunction

  // Responder: reply byte is presented only in the final gap cycle after each payload strobe.
  logic [7:0] r_cmd, r_reply;
  int         r_idx, r_cnt;
  logic       r_have;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd <= '0; r_reply <= '0; r_idx <= 0; r_cnt <= 0; r_have <= 1'b0;
    end else begin
      if (r_cnt < 1000) r_cnt <= r_cnt + 1;
      if (data_out_strobe) begin
        r_cnt <= 1;
        if (data_out_start) begin
          r_cmd <= data_out; r_idx <= 0; r_have <= 1'b0;
        end else begin
          r_reply <= reply(r_cmd, r_idx, data_out);
          r_idx   <= r_idx + 1;
          r_have  <= 1'b1;
        end
      end
    end
  end
  assign data_in = (r_have && r_cnt == GAP) ? r_reply : 8'hEE;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic report_fail(input string name, input string what);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"},  rsp_data, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_strobe"},    data_out_strobe, 0);
    chk({tag, "_start"},     data_out_start, 0);
    chk({tag, "_data_out"},  data_out, 0);
  endtask

  task automatic model_accept(input int t, input logic [7:0] c, input logic [LW-1:0] ln,
                              input logic [8*MAX_LEN-1:0] d);
    int   l;
    bus_t be;
    rsp_t re;
    l = (int'(ln) > MAX_LEN) ? MAX_LEN : int'(ln);
    for (int k = 0; k <= l; k++) begin
      be.cyc   = t + 1 + k * (GAP + 1);
      be.start = (k == 0);
      if (k == 0) be.b = c;
      else        be.b = d[8*(k-1) +: 8];
      exp_bus.push_back(be);
    end
    re.cyc = t + 1 + (l + 1) * (GAP + 1);
    re.d   = '0;
    for (int i = 0; i < l; i++) re.d[8*i +: 8] = reply(c, i, d[8*i +: 8]);
    exp_rsp.push_back(re);
    free_at = re.cyc + 1;
  endtask

  initial begin : monitor
    bit   idle;
    bus_t be;
    rsp_t re;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_bus.delete();
        exp_rsp.delete();
        free_at  = cyc;
        last_rsp = '0;
        chk_reset_outputs("rst_hold");
      end else begin
        idle = (cyc >= free_at);
        chk("req_ready", req_ready, idle);
        chk("busy", busy, !idle);
        while (exp_bus.size() > 0 && exp_bus[0].cyc < cyc) begin
          chk("bus_missing_strobe_cycle", cyc, exp_bus[0].cyc);
          void'(exp_bus.pop_front());
        end
        if (data_out_strobe) begin
          if (exp_bus.size() == 0) report_fail("bus_unexpected_strobe", "strobe with no frame pending");
          else begin
            be = exp_bus.pop_front();
            chk("strobe_cycle", cyc, be.cyc);
            chk("strobe_start", data_out_start, be.start);
            chk("strobe_byte", data_out, be.b);
          end
        end else begin
          chk("idle_data_out", data_out, 0);
          chk("start_without_strobe", data_out_start, 0);
        end
        while (exp_rsp.size() > 0 && exp_rsp[0].cyc < cyc) begin
          chk("rsp_missing_cycle", cyc, exp_rsp[0].cyc);
          void'(exp_rsp.pop_front());
        end
        if (rsp_valid) begin
          if (exp_rsp.size() == 0) report_fail("rsp_unexpected", "rsp_valid with no frame pending");
          else begin
            re = exp_rsp.pop_front();
            chk("rsp_cycle", cyc, re.cyc);
            chk("rsp_data", rsp_data, re.d);
            last_rsp = re.d;
          end
        end else if (idle) begin
          chk("rsp_hold", rsp_data, last_rsp);
        end
        if (idle && req_valid) model_accept(cyc, req_cmd, req_len, req_data);
      end
    end
  end

  task automatic send(input logic [7:0] c, input logic [LW-1:0] ln, input logic [8*MAX_LEN-1:0] d);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    while (!req_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) report_fail("ready_timeout", "req_ready never rose");
    req_valid = 1'b1; req_cmd = c; req_len = ln; req_data = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic poke;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_cmd   = 8'($urandom_range(0, 4));
    req_len   = LW'($urandom_range(0, 7));
    req_data  = $urandom;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int g;
    g = 0;
    while ((cyc < free_at || exp_rsp.size() > 0) && g < 500) begin
      @(posedge clk);
      g++;
    end
    if (g >= 500) report_fail("idle_timeout", "frame never completed");
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk_reset_outputs("reset_init");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    send(8'h00, 3'd3, $urandom);
    wait_idle();
    send(8'h04, 3'd2, 32'h0000_0253);
    wait_idle();
    send(8'h01, 3'd0, $urandom);
    wait_idle();
    send(8'h02, 3'd7, 32'hDEAD_BEEF);
    repeat (2) @(posedge clk);
    poke();
    wait_idle();

    // Abort a frame while payload byte 1 is on the bus.
    send(8'h03, 3'd3, 32'h0044_3322);
    repeat (6) @(posedge clk);
    #2;
    chk("pre_reset_strobe", data_out_strobe, 1);
    chk("pre_reset_byte", data_out, 8'h33);
    #1 reset_n = 1'b0;
    #1 chk_reset_outputs("reset_async");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    send(8'h00, 3'd3, $urandom);
    wait_idle();

    for (int n = 0; n < 60; n++) begin
      send(8'($urandom_range(0, 4)), LW'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        poke();
      end
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    repeat (3) @(posedge clk);
    chk("bus_queue_drained", exp_bus.size(), 0);
    chk("rsp_queue_drained", exp_rsp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
